// File: rtl/shift_pkg.sv
// Shared definitions for the shifter sequencing controller:
// op codes, FSM state encoding and datapath sizing.
package shift_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  localparam logic [2:0] SH_LSL = 3'b000;
  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_ROR = 3'b011;
  localparam logic [2:0] SH_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= SH_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position shift step: combinational, one bit per call.
// Illegal op codes pass the word through unchanged and raise illegal_o.
module shift_step
  import shift_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] w_i,
  output logic [W-1:0] next_w_o,
  output logic         illegal_o
);

  always_comb begin
    next_w_o  = w_i;
    illegal_o = !op_is_legal(op_i);
    case (op_i)
      SH_LSL:  next_w_o = {w_i[W-2:0], 1'b0};
      SH_LSR:  next_w_o = {1'b0, w_i[W-1:1]};
      SH_ASR:  next_w_o = {w_i[W-1], w_i[W-1:1]};
      SH_ROR:  next_w_o = {w_i[0], w_i[W-1:1]};
      SH_ROL:  next_w_o = {w_i[W-2:0], w_i[W-1]};
      default: next_w_o = w_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Two-requester round-robin front end for an iterative one-bit-per-cycle
// shifter; the result is held with its requester ID until accepted.
module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [WIDTH-1:0] req1_amt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy
);
  import shift_pkg::*;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   work_q;
  logic [AMT_W-1:0]   cnt_q;
  logic               id_q;
  logic               rr_last_q;
  logic               resp_valid_q;
  logic               resp_id_q;
  logic [WIDTH-1:0]   resp_data_q;
  logic               resp_err_q;
  logic               busy_q;

  logic               grant0;
  logic               grant1;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_data;
  logic [AMT_W-1:0]   sel_amt;
  logic [WIDTH-1:0]   work_d;
  logic               step_illegal;
  logic               unused_amt_hi;

  // Only the low AMT_W amount bits matter; the rest wrap the amount modulo WIDTH.
  assign unused_amt_hi = ^{req0_amt[WIDTH-1:AMT_W], req1_amt[WIDTH-1:AMT_W]};

  // Grant depends only on valids and the last winner, never on ready.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || rr_last_q);
    grant1 = req1_valid && (!req0_valid || !rr_last_q);
  end

  always_comb begin
    sel_op   = req0_op;
    sel_data = req0_data;
    sel_amt  = req0_amt[AMT_W-1:0];
    if (grant1) begin
      sel_op   = req1_op;
      sel_data = req1_data;
      sel_amt  = req1_amt[AMT_W-1:0];
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && grant0;
  assign req1_ready = (state_q == ST_IDLE) && grant1;

  shift_step #(
    .W (WIDTH)
  ) u_step (
    .op_i      (op_q),
    .w_i       (work_q),
    .next_w_o  (work_d),
    .illegal_o (step_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= SH_LSL;
      work_q       <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      rr_last_q    <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            op_q      <= sel_op;
            work_q    <= sel_data;
            cnt_q     <= sel_amt;
            id_q      <= grant1;
            rr_last_q <= grant1;
            busy_q    <= 1'b1;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Illegal ops skip the iteration entirely and return the operand.
          if (step_illegal || (cnt_q == '0)) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= work_q;
            resp_id_q    <= id_q;
            resp_err_q   <= step_illegal;
            state_q      <= ST_DONE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q - {{(AMT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus random
// traffic compared against a plain-arithmetic reference model.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data, req0_amt, req1_amt;
  logic        resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [15:0] resp_data;

  int   checks   = 0;
  int   failures = 0;
  logic rr_last_m = 1'b1;

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  // Reference result: {err, data} from whole-word arithmetic.
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] d,
                                        input logic [15:0] amt);
    int k;
    logic [31:0] dd;
    logic signed [15:0] sd;
    logic [15:0] r;
    logic err;
    k = int'(amt) % 16;
    dd = {d, d};
    sd = d;
    err = 1'b0;
    case (op)
      3'd0: r = d << k;
      3'd1: r = d >> k;
      3'd2: r = sd >>> k;
      3'd3: r = 16'(dd >> k);
      3'd4: r = 16'((dd << k) >> 16);
      default: begin r = d; err = 1'b1; end
    endcase
    return {err, r};
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [15:0] amt);
    return (op > 3'd4) ? 1 : (int'(amt) % 16) + 1;
  endfunction

  task automatic drive_req(input logic id, input logic v, input logic [2:0] op,
                           input logic [15:0] d, input logic [15:0] a);
    if (id) begin
      req1_valid = v; req1_op = op; req1_data = d; req1_amt = a;
    end else begin
      req0_valid = v; req0_op = op; req0_data = d; req0_amt = a;
    end
  endtask

  // Called just after an accept edge; returns cycles until resp_valid.
  task automatic wait_resp(output int lat, output logic viol, output logic to);
    lat = 0; viol = 1'b0; to = 1'b0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (req0_ready || req1_ready) viol = 1'b1;
      if (resp_valid) break;
      if (lat > 40) begin to = 1'b1; break; end
    end
  endtask

  task automatic finish_resp(input int stall, output logic cleared, output logic stable);
    logic [15:0] d0;
    logic i0;
    d0 = resp_data; i0 = resp_id; stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_data !== d0 || resp_id !== i0 || req0_ready || req1_ready)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    cleared = !resp_valid;
  endtask

  task automatic run_op(input logic id, input logic [2:0] op, input logic [15:0] d,
                        input logic [15:0] a, input int stall,
                        output logic [15:0] rdata, output logic rid, output logic rerr,
                        output int lat, output logic viol, output logic to,
                        output logic ok_clear);
    int n;
    logic stable;
    rdata = '0; rid = 1'b0; rerr = 1'b0; lat = 0; viol = 1'b0; ok_clear = 1'b0;
    to = 1'b0;
    drive_req(id, 1'b1, op, d, a);
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      to = 1'b1;
      drive_req(id, 1'b0, 3'd0, 16'd0, 16'd0);
      return;
    end
    @(posedge clk);
    rr_last_m = id;
    #1;
    drive_req(id, 1'b0, 3'd0, 16'd0, 16'd0);
    wait_resp(lat, viol, to);
    rdata = resp_data; rid = resp_id; rerr = resp_err;
    if (to) return;
    finish_resp(stall, ok_clear, stable);
    if (!stable) viol = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rr_last_m = 1'b1;
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    drive_req(1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive_req(1'b1, 1'b0, 3'd0, 16'd0, 16'd0);
    do_reset();
    #1;
    checks++;
    if ({resp_valid, resp_id, resp_err, busy, resp_data} !== 20'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b id=%0b err=%0b busy=%0b data=%h, expected all 0",
               resp_valid, resp_id, resp_err, busy, resp_data);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got r0=%0b r1=%0b expected 0 0", req0_ready, req1_ready);
    end
  endtask

  task automatic test_directed();
    logic        ids [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  ops [5]  = '{3'd3, 3'd2, 3'd1, 3'd4, 3'd0};
    logic [15:0] dats [5] = '{16'h000B, 16'h8000, 16'h8000, 16'h8001, 16'h0001};
    logic [15:0] amts [5] = '{16'd4, 16'd3, 16'd3, 16'd1, 16'h0014};
    logic [15:0] exps [5] = '{16'hB000, 16'hF000, 16'h1000, 16'h0003, 16'h0010};
    int          elat [5] = '{5, 4, 4, 2, 5};
    logic [15:0] rd; logic rid, rerr, viol, to, clr; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ids[i], ops[i], dats[i], amts[i], 0, rd, rid, rerr, lat, viol, to, clr);
      checks++;
      if (to || rd !== exps[i] || rid !== ids[i] || rerr !== 1'b0) begin
        failures++;
        $display("FAIL directed_%0d: got data=%h id=%0b err=%0b to=%0b expected data=%h id=%0b err=0",
                 i, rd, rid, rerr, to, exps[i], ids[i]);
      end
      checks++;
      if (lat != elat[i] || viol || !clr) begin
        failures++;
        $display("FAIL directed_lat_%0d: got lat=%0d viol=%0b cleared=%0b expected lat=%0d viol=0 cleared=1",
                 i, lat, viol, clr, elat[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    int lat; logic viol, to, clr, st;
    do_reset();
    drive_req(1'b0, 1'b1, 3'd0, 16'h0001, 16'd1);
    drive_req(1'b1, 1'b1, 3'd0, 16'h0002, 16'd1);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL arb_first_grant: got r0=%0b r1=%0b expected 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
    wait_resp(lat, viol, to);
    checks++;
    if (to || viol || resp_id !== 1'b0 || resp_data !== 16'h0002) begin
      failures++;
      $display("FAIL arb_resp0: got id=%0b data=%h viol=%0b to=%0b expected id=0 data=0002",
               resp_id, resp_data, viol, to);
    end
    finish_resp(0, clr, st);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL arb_second_grant: got r1=%0b expected 1", req1_ready);
    end
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 3'd0, 16'd0, 16'd0);
    wait_resp(lat, viol, to);
    checks++;
    if (to || viol || resp_id !== 1'b1 || resp_data !== 16'h0004) begin
      failures++;
      $display("FAIL arb_resp1: got id=%0b data=%h viol=%0b to=%0b expected id=1 data=0004",
               resp_id, resp_data, viol, to);
    end
    finish_resp(0, clr, st);
    rr_last_m = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op [2];
    logic [15:0] d [2], a [2];
    logic        g;
    logic [16:0] exp;
    int lat; logic viol, to, clr, st;
    for (int r = 0; r < 2; r++) begin
      op[r] = 3'($urandom_range(0, 7)); d[r] = 16'($urandom); a[r] = 16'($urandom);
      drive_req(r[0], 1'b1, op[r], d[r], a[r]);
    end
    #1;
    for (int it = 0; it < 8; it++) begin
      g = !rr_last_m;
      checks++;
      if (req0_ready !== !g || req1_ready !== g) begin
        failures++;
        $display("FAIL b2b_grant_%0d: got r0=%0b r1=%0b expected r0=%0b r1=%0b",
                 it, req0_ready, req1_ready, !g, g);
      end
      @(posedge clk);
      rr_last_m = g;
      exp = model(op[g], d[g], a[g]);
      #1;
      op[g] = 3'($urandom_range(0, 7)); d[g] = 16'($urandom); a[g] = 16'($urandom);
      drive_req(g, 1'b1, op[g], d[g], a[g]);
      wait_resp(lat, viol, to);
      checks++;
      if (to || viol || resp_id !== g || {resp_err, resp_data} !== exp) begin
        failures++;
        $display("FAIL b2b_resp_%0d: got id=%0b err=%0b data=%h viol=%0b expected id=%0b err=%0b data=%h",
                 it, resp_id, resp_err, resp_data, viol, g, exp[16], exp[15:0]);
      end
      finish_resp(0, clr, st);
    end
    drive_req(1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive_req(1'b1, 1'b0, 3'd0, 16'd0, 16'd0);
  endtask

  task automatic test_zero_illegal();
    logic [2:0]  ops [4]  = '{3'd0, 3'd7, 3'd5, 3'd6};
    logic [15:0] dats [4] = '{16'h1234, 16'hABCD, 16'h5A5A, 16'h8001};
    logic [15:0] amts [4] = '{16'd0, 16'd9, 16'd15, 16'd16};
    logic        errs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] rd; logic rid, rerr, viol, to, clr; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(i[0], ops[i], dats[i], amts[i], 1, rd, rid, rerr, lat, viol, to, clr);
      checks++;
      if (to || lat != 1 || rd !== dats[i] || rerr !== errs[i] || rid !== i[0] || viol) begin
        failures++;
        $display("FAIL zero_illegal_%0d: got lat=%0d data=%h err=%0b id=%0b viol=%0b expected lat=1 data=%h err=%0b id=%0b",
                 i, lat, rd, rerr, rid, viol, dats[i], errs[i], i[0]);
      end
    end
  endtask

  task automatic test_hold();
    int lat; logic viol, to, clr, st, bad;
    drive_req(1'b0, 1'b1, 3'd0, 16'h00F0, 16'd2);
    #1;
    while (!req0_ready) begin @(posedge clk); #1; end
    @(posedge clk); rr_last_m = 1'b0; #1;
    drive_req(1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
    wait_resp(lat, viol, to);
    drive_req(1'b1, 1'b1, 3'd3, 16'h0001, 16'd1);
    bad = to;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_data !== 16'h03C0 || resp_id !== 1'b0 || req1_ready || !busy)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_stable: got v=%0b data=%h id=%0b r1=%0b expected v=1 data=03c0 id=0 r1=0",
               resp_valid, resp_data, resp_id, req1_ready);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: got v=%0b r1=%0b expected v=0 r1=1", resp_valid, req1_ready);
    end
    @(posedge clk); rr_last_m = 1'b1; #1;
    drive_req(1'b1, 1'b0, 3'd0, 16'd0, 16'd0);
    wait_resp(lat, viol, to);
    checks++;
    if (to || resp_data !== 16'h8000 || resp_id !== 1'b1 || lat != 2) begin
      failures++;
      $display("FAIL hold_next: got data=%h id=%0b lat=%0d expected data=8000 id=1 lat=2",
               resp_data, resp_id, lat);
    end
    finish_resp(0, clr, st);
  endtask

  task automatic test_mid_reset();
    logic seen;
    logic [15:0] rd; logic rid, rerr, viol, to, clr; int lat;
    drive_req(1'b0, 1'b1, 3'd0, 16'hFFFF, 16'd15);
    #1;
    while (!req0_ready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_last_m = 1'b1;
    checks++;
    if ({resp_valid, resp_id, resp_err, busy, resp_data} !== 20'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%0b id=%0b err=%0b busy=%0b data=%h expected all 0",
               resp_valid, resp_id, resp_err, busy, resp_data);
    end
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (resp_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_no_resp: got resp_valid/busy=1 after reset, expected 0");
    end
    run_op(1'b1, 3'd4, 16'h1234, 16'd4, 0, rd, rid, rerr, lat, viol, to, clr);
    checks++;
    if (to || rd !== 16'h2341 || rid !== 1'b1 || rerr !== 1'b0 || lat != 5) begin
      failures++;
      $display("FAIL midreset_fresh: got data=%h id=%0b err=%0b lat=%0d expected data=2341 id=1 err=0 lat=5",
               rd, rid, rerr, lat);
    end
  endtask

  task automatic test_random();
    logic id; logic [2:0] op; logic [15:0] d, a;
    logic [16:0] exp;
    logic [15:0] rd; logic rid, rerr, viol, to, clr; int lat;
    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      a  = 16'($urandom);
      exp = model(op, d, a);
      run_op(id, op, d, a, $urandom_range(0, 3), rd, rid, rerr, lat, viol, to, clr);
      checks++;
      if (to || {rerr, rd} !== exp || rid !== id) begin
        failures++;
        $display("FAIL random_%0d op=%0d d=%h a=%h: got err=%0b data=%h id=%0b expected err=%0b data=%h id=%0b",
                 i, op, d, a, rerr, rd, rid, exp[16], exp[15:0], id);
      end
      checks++;
      if (lat != model_lat(op, a) || viol || !clr) begin
        failures++;
        $display("FAIL random_lat_%0d: got lat=%0d viol=%0b cleared=%0b expected lat=%0d",
                 i, lat, viol, clr, model_lat(op, a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_arbitration();
    test_back_to_back();
    test_zero_illegal();
    test_hold();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing and arbitration controller for the ALU shifter path. Two requesters share one iterative 16-bit shift engine through valid/ready handshakes. The engine moves one bit position per cycle for LSL, LSR, ASR, ROR and ROL. The controller returns the result with a requester ID and holds it until the consumer accepts it.

Parameters:
WIDTH, 16, datapath width in bits.
AMT_W, 4, number of significant shift-amount bits; shift amount = amt[AMT_W-1:0], i.e. modulo 16.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  controller accepts requester 0 this cycle.
req0_op  input  3  operation code: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL; 101-111 illegal.
req0_data  input  WIDTH  operand.
req0_amt  input  WIDTH  shift amount; only the low AMT_W bits are used.
req1_valid, req1_ready, req1_op, req1_data, req1_amt  same widths and meanings as the requester 0 ports, for requester 1.
resp_valid  output  1  result available.
resp_ready  input  1  consumer accepts the result.
resp_id  output  1  ID of the requester the result belongs to.
resp_data  output  WIDTH  shifted result.
resp_err  output  1  the operation code was illegal.
busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset: synchronous, active-high, one cycle. Takes priority over every other event, including mid-BUSY and mid-DONE; any in-flight operation is discarded with no response.
- Reset values: state=IDLE; resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0; rr_last=1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: reqX_ready = grantX. Grant is combinational from the valids and rr_last only, never from ready. If one requester is valid, it is granted. If both are valid, the requester that is not rr_last is granted. On acceptance (valid&&ready): latch op, data and amt[3:0] into the work registers; set cnt=amt[3:0]; set rr_last=granted ID; go to BUSY.
  - BUSY: all reqX_ready=0.
    - cnt!=0: shift the work register by one position, then cnt--.
    - cnt==0: go to DONE and register resp_data=work, resp_id, resp_err.
  - DONE: resp_valid=1; resp_id, resp_data and resp_err stay stable.
    - On resp_ready=1: go to IDLE and clear resp_valid.
    - New requests are accepted no earlier than the cycle after leaving DONE.
- Latency: request accepted at edge N; resp_valid is high starting after edge N+k+1, where k=amt[3:0]. k=0 therefore gives resp_valid one cycle after acceptance, with resp_data = operand.
- Per-step arithmetic, one bit per step:
  - LSL: {w[14:0],0}
  - LSR: {0,w[15:1]}
  - ASR: {w[15],w[15:1]}
  - ROR: {w[0],w[15:1]}
  - ROL: {w[14:0],w[15]}
- Illegal op: no shifting. Go directly BUSY to DONE in one cycle regardless of amt; resp_data = operand, resp_err=1.
- amt upper bits are ignored, e.g. amt=20 is treated as 4 and amt=16 as 0.
- Requests are never lost. A requester holds valid and its payload stable until it sees ready.
- The arbiter never grants a requester whose valid is 0.

Decomposition:
- Shared package shift_pkg holds:
  - op codes SH_LSL=3'b000, SH_LSR=3'b001, SH_ASR=3'b010, SH_ROR=3'b011, SH_ROL=3'b100;
  - FSM state encodings ST_IDLE, ST_BUSY, ST_DONE;
  - WIDTH=16.
- One sub-module: shift_step, a purely combinational single-bit step taking (op, w) and returning (next_w, illegal).
- The top level contains the FSM, counter, round-robin arbiter and output registers.

Test Plan:
1. After reset: req0 ROR data=0x000B amt=4 -> accepted at edge N; resp_valid first high after edge N+5; resp_data=0xB000, resp_id=0, resp_err=0.
2. req1 ASR data=0x8000 amt=3, then LSR same data/amt -> resp_data=0xF000 then 0x1000; ROL 0x8001 amt=1 -> 0x0003; amt=0x0014 with LSL 0x0001 -> 0x0010.
3. Both valid in the same cycle (req0 LSL 0x0001 amt=1, req1 LSL 0x0002 amt=1) -> req0 served first (resp_id=0, data=0x0002), then req1 (resp_id=1, data=0x0004). Repeating with both held valid alternates the grant each time.
4. amt=0 and illegal op=3'b111 -> resp after one cycle with resp_data=operand; resp_err=0 for amt=0 and resp_err=1 for op=3'b111; req0_ready/req1_ready=0 throughout BUSY and DONE.
5. resp_ready held low for 5 cycles in DONE -> resp_valid, resp_data and resp_id stay stable and no request is accepted; resp_ready=1 -> IDLE next cycle.
6. Assert rst for one cycle mid-BUSY (amt=15) -> next cycle state IDLE, all outputs 0, no response ever emitted; a fresh request afterwards completes correctly.
